// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Constants and types used by the instruction-memory loader and the CPU
// controller.
//   FILL_WORD      : word returned for any address that holds no loaded code.
//                    It encodes "branch-if-equal r0,r0 to self", so a CPU that
//                    runs off the end of the program parks in a tight loop.
//   loader_state_t : loader FSM state encoding.
//   OP_*           : 4-bit major opcodes held in instruction bits [15:12].
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int WORD_W = 16;

    // Major opcodes in instruction[15:12].
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // BEQ r0,r0 with a zero offset: branches to itself forever.
    localparam logic [WORD_W-1:0] FILL_WORD = {OP_BEQ, 12'h000};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2,
        RUN     = 2'd3
    } loader_state_t;

    // True when a word is the parking instruction.
    function automatic logic is_fill(input logic [WORD_W-1:0] word);
        return word == FILL_WORD;
    endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// DEPTH x 16 instruction storage: synchronous single-port write, asynchronous
// read. Contents are never cleared; the loader decides which words are
// visible to the CPU.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// -----------------------------------------------------------------------------
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WORD_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WORD_W-1:0]          rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program as a little-endian byte stream, assembles 16-bit words
// into imem_ram and then releases the CPU controller to run from it.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load_start  : pulse, starts a new load (wins over everything else)
//   load_end    : pulse, ends the load and releases the CPU
//   rx_data     : program byte, low byte of each word first
//   rx_valid    : rx_data valid
//   rx_ready    : loader accepts rx_data this cycle
//   pc          : CPU instruction word address
//   instruction : mem[pc] when running and pc is inside the program, else FILL_WORD
//   cpu_rst     : registered CPU reset, low only while running
//   word_count  : words written since load_start, saturating at DEPTH
//   overflow    : sticky, a word arrived while memory was full
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_end,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic [15:0]              pc,
    output logic [15:0]              instruction,
    output logic                     cpu_rst,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    loader_state_t   state_reg, state_next;
    logic [7:0]      low_byte_reg, low_byte_next;
    logic [CW-1:0]   word_count_reg, word_count_next;
    logic            overflow_reg, overflow_next;
    logic            cpu_rst_reg, cpu_rst_next;

    logic            loading;
    logic            xfer;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [15:0]     mem_wdata;
    logic [15:0]     mem_rdata;
    logic [15:0]     word_count_ext;
    logic            pc_visible;

    // A byte is never taken in a cycle that carries a control pulse, so a
    // pulse cannot race a half-finished word.
    assign loading  = (state_reg == LOAD_LO) || (state_reg == LOAD_HI);
    assign rx_ready = loading && !load_end && !load_start;
    assign xfer     = rx_valid && rx_ready;

    always_comb begin
        state_next      = state_reg;
        low_byte_next   = low_byte_reg;
        word_count_next = word_count_reg;
        overflow_next   = overflow_reg;
        mem_we          = 1'b0;
        mem_waddr       = word_count_reg[AW-1:0];
        mem_wdata       = {rx_data, low_byte_reg};

        if (load_start) begin
            state_next      = LOAD_LO;
            low_byte_next   = '0;
            word_count_next = '0;
            overflow_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // load_end alone does nothing until a load has begun.
                end
                LOAD_LO: begin
                    if (load_end) begin
                        state_next = RUN;
                    end else if (xfer) begin
                        low_byte_next = rx_data;
                        state_next    = LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    if (load_end) begin
                        // The held low byte is simply abandoned.
                        state_next    = RUN;
                        low_byte_next = '0;
                    end else if (xfer) begin
                        state_next = LOAD_LO;
                        if (word_count_reg == FULL_COUNT) begin
                            overflow_next = 1'b1;
                        end else begin
                            mem_we          = 1'b1;
                            word_count_next = word_count_reg + CW'(1);
                        end
                    end
                end
                RUN: begin
                    // Only load_start (handled above) or rst leave RUN.
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Release the CPU only once the FSM has already sat in RUN for an
        // edge, and re-assert it on the same edge that leaves RUN.
        cpu_rst_next = !((state_reg == RUN) && (state_next == RUN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            low_byte_reg   <= '0;
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
            cpu_rst_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            low_byte_reg   <= low_byte_next;
            word_count_reg <= word_count_next;
            overflow_reg   <= overflow_next;
            cpu_rst_reg    <= cpu_rst_next;
        end
    end

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (pc[AW-1:0]),
        .rdata (mem_rdata)
    );

    // The full 16-bit pc is compared, so addresses past DEPTH cannot alias
    // back onto low memory through the truncated RAM address.
    assign word_count_ext = {{(16-CW){1'b0}}, word_count_reg};
    assign pc_visible     = (state_reg == RUN) && (pc < word_count_ext);
    assign instruction    = pc_visible ? mem_rdata : FILL_WORD;

    assign cpu_rst    = cpu_rst_reg;
    assign word_count = word_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed scenarios for imem_loader (DEPTH=64). Stimulus queues the expected
// accepted bytes and expected observations; a monitor on the falling edge
// pops and compares them whenever a byte transfer or an observation request
// is presented.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 64;

    localparam int K_WC  = 0;
    localparam int K_OVF = 1;
    localparam int K_CPU = 2;
    localparam int K_INS = 3;
    localparam int K_RDY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        load_end = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] pc = 16'h0000;
    logic [15:0] instruction;
    logic        cpu_rst;
    logic [6:0]  word_count;
    logic        overflow;

    imem_loader #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_end    (load_end),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_rst     (cpu_rst),
        .word_count  (word_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t        obs_q[$];
    logic [7:0]  xfer_q[$];
    logic        probe_req = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    exp_t        cur;
    logic [15:0] act;
    logic [7:0]  exp_byte;

    function automatic string kname(input int k);
        case (k)
            K_WC:    return "word_count";
            K_OVF:   return "overflow";
            K_CPU:   return "cpu_rst";
            K_INS:   return "instruction";
            K_RDY:   return "rx_ready";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: every accepted byte and every observation request is checked.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            vectors++;
            if (xfer_q.size() == 0) begin
                miscompares++;
                $display("FAIL xfer: byte %02h accepted, required no transfer", rx_data);
            end else begin
                exp_byte = xfer_q.pop_front();
                if (exp_byte !== rx_data) begin
                    miscompares++;
                    $display("FAIL xfer: accepted %02h, required %02h", rx_data, exp_byte);
                end else begin
                    $display("vec %0d xfer byte %02h ok", vectors, rx_data);
                end
            end
        end
        if (probe_req) begin
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL probe: no expected value queued");
            end else begin
                cur = obs_q.pop_front();
                case (cur.kind)
                    K_WC:    act = {9'd0, word_count};
                    K_OVF:   act = {15'd0, overflow};
                    K_CPU:   act = {15'd0, cpu_rst};
                    K_INS:   act = instruction;
                    default: act = {15'd0, rx_ready};
                endcase
                if (act !== cur.exp) begin
                    miscompares++;
                    $display("FAIL %s (pc=%04h): got %04h, required %04h",
                             kname(cur.kind), pc, act, cur.exp);
                end else begin
                    $display("vec %0d %s (pc=%04h) = %04h ok", vectors, kname(cur.kind), pc, act);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int k, input logic [15:0] e);
        exp_t t;
        t.kind = k;
        t.exp  = e;
        obs_q.push_back(t);
        probe_req = 1'b1;
        tick();
        probe_req = 1'b0;
    endtask

    task automatic probe_instr(input logic [15:0] a, input logic [15:0] e);
        pc = a;
        probe(K_INS, e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        xfer_q.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        probe(K_CPU, 16'h0001);
        probe(K_RDY, 16'h0000);
        probe(K_WC,  16'h0000);
        probe(K_OVF, 16'h0000);
        probe_instr(16'h0000, 16'h6000);
        rst = 1'b0;
        tick();

        // load_end alone in IDLE keeps the CPU held
        pulse_end();
        probe(K_CPU, 16'h0001);

        // Two-word load
        pulse_start();
        probe(K_RDY, 16'h0001);
        send_word(16'h1234);
        send_word(16'h5678);
        probe(K_WC, 16'h0002);
        pulse_end();
        probe(K_CPU, 16'h0001);
        probe(K_CPU, 16'h0000);
        probe_instr(16'h0000, 16'h1234);
        probe_instr(16'h0001, 16'h5678);
        probe_instr(16'h0002, 16'h6000);

        // load_start in RUN, then an odd byte count
        pulse_start();
        probe(K_CPU, 16'h0001);
        probe(K_WC,  16'h0000);
        probe_instr(16'h0000, 16'h6000);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        probe(K_WC, 16'h0001);
        pulse_end();
        tick();
        probe_instr(16'h0000, 16'hBBAA);
        probe_instr(16'h0001, 16'h6000);
        probe(K_CPU, 16'h0000);

        // load_end with rx_valid high, then load_start+load_end together
        pulse_start();
        send_word(16'h0201);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        load_end = 1'b1;
        probe(K_RDY, 16'h0000);
        rx_valid   = 1'b0;
        load_end   = 1'b1;
        load_start = 1'b1;
        probe(K_WC, 16'h0001);
        load_end   = 1'b0;
        load_start = 1'b0;
        probe(K_CPU, 16'h0001);
        probe(K_WC,  16'h0000);
        probe(K_RDY, 16'h0001);
        send_word(16'h2211);
        pulse_end();
        tick();
        probe_instr(16'h0000, 16'h2211);

        // Overflow: 65 words into 64 slots
        pulse_start();
        for (int i = 0; i < 65; i++) begin
            send_word(16'hA000 + 16'(i));
        end
        probe(K_WC,  16'd64);
        probe(K_OVF, 16'h0001);
        pulse_end();
        tick();
        probe_instr(16'd63,   16'hA03F);
        probe_instr(16'd62,   16'hA03E);
        probe_instr(16'd0,    16'hA000);
        probe_instr(16'd64,   16'h6000);
        probe_instr(16'h0400, 16'h6000);
        probe(K_OVF, 16'h0001);

        // rst mid-word, then a fresh one-word load
        pulse_start();
        probe(K_OVF, 16'h0000);
        send_byte(8'h99);
        rst = 1'b1;
        probe(K_CPU, 16'h0001);
        probe(K_RDY, 16'h0000);
        probe(K_WC,  16'h0000);
        probe(K_OVF, 16'h0000);
        rst = 1'b0;
        tick();
        pulse_end();
        probe(K_CPU, 16'h0001);
        pulse_start();
        send_word(16'h0123);
        probe(K_WC, 16'h0001);
        pulse_end();
        tick();
        probe_instr(16'h0000, 16'h0123);
        probe_instr(16'h0001, 16'h6000);
        probe_instr(16'h0040, 16'h6000);
        probe(K_CPU, 16'h0000);

        tick();
        tick();
        vectors++;
        if (xfer_q.size() != 0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d bytes and %0d probes left, required 0 and 0",
                     xfer_q.size(), obs_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, meaning number of 16-bit instruction words held (power of two, 16..1024).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load_start  input  1  single-cycle pulse; begins a new program load.
REQ-005 load_end  input  1  single-cycle pulse; ends the current load and releases the CPU.
REQ-006 rx_data  input  8  program byte stream, low byte of each word first.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts rx_data this cycle; a transfer occurs when rx_valid && rx_ready.
REQ-009 pc  input  16  instruction word address from the CPU controller.
REQ-010 instruction  output  16  instruction word for pc, combinational, same cycle.
REQ-011 cpu_rst  output  1  holds the CPU controller in reset while high.
REQ-012 word_count  output  clog2(DEPTH)+1  words written since the last load_start, saturating at DEPTH.
REQ-013 overflow  output  1  sticky; a word arrived with word_count == DEPTH.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD_LO, LOAD_HI and RUN.
REQ-015 IDLE: rx_ready=0, cpu_rst=1; load_start -> LOAD_LO; load_end ignored.
REQ-016 load_start in any state SHALL go to LOAD_LO next cycle and clear word_count, overflow and any held low byte.
REQ-017 LOAD_LO: rx_ready = !load_end && !load_start; on a transfer, latch rx_data as low byte and go to LOAD_HI.
REQ-018 LOAD_HI: rx_ready = !load_end && !load_start; on a transfer, write {rx_data, low byte} to mem[word_count], increment word_count, go to LOAD_LO.
REQ-019 If word_count == DEPTH when a word completes, the word SHALL be dropped, word_count held, overflow set to 1, and the state SHALL return to LOAD_LO.
REQ-020 load_end in LOAD_LO or LOAD_HI SHALL go to RUN next cycle; a pending low byte is discarded; same-cycle rx_valid is not accepted.
REQ-021 load_start and load_end in the same cycle: load_start wins.
REQ-022 RUN: rx_ready=0, cpu_rst=0; leaves RUN only on load_start or rst.
REQ-023 cpu_rst SHALL be a registered output, high in every state except RUN, and go low on the first clk edge after entering RUN.
REQ-024 instruction = mem[pc] when state==RUN and pc < word_count, else FILL_WORD (16'h6000, branch-if-equal r0,r0 to self = halt).
REQ-025 pc bits above clog2(DEPTH) SHALL participate in the compare, so pc >= DEPTH always yields FILL_WORD without aliasing.
REQ-026 Memory writes SHALL be synchronous, single port; the read is asynchronous; no read-during-write hazard exists because reads are masked outside RUN.
REQ-027 Memory contents are not cleared by load_start or rst; only word_count gates visibility.

Reset
REQ-028 On rst: state=IDLE, cpu_rst=1, rx_ready=0, word_count=0, overflow=0, low-byte register=0; instruction reads FILL_WORD.
REQ-029 rst during LOAD_LO or LOAD_HI SHALL abort the load; a half-received word is discarded.
REQ-030 After rst deassertion, the CPU stays held until a complete load_start ... load_end sequence.

Structure
REQ-031 A shared package SHALL hold FILL_WORD, the state enum type and the opcode constants shared with the CPU controller.
REQ-032 The storage array SHALL be a separate sub-module imem_ram (DEPTH x 16, sync write, async read); the FSM, byte assembly and read mask live in imem_loader.

Verification
REQ-033 Reset, then load_start, bytes 34 12 78 56, load_end -> word_count=2, mem[0]=16'h1234, mem[1]=16'h5678; cpu_rst low 2 cycles after load_end; pc=1 gives 16'h5678, pc=2 gives 16'h6000.
REQ-034 Load 3 bytes AA BB CC then load_end -> word_count=1, mem[0]=16'hBBAA, CC discarded; pc=1 gives 16'h6000.
REQ-035 DEPTH=64, send 65 words -> word_count=64, overflow=1, mem[63] holds word 64; word 65 not written.
REQ-036 rx_valid held high with load_end pulsed -> rx_ready=0 that cycle, no byte consumed; load_start and load_end together -> LOAD_LO, cpu_rst stays 1.
REQ-037 rst asserted mid-word, then a new load of 1 word 16'h0123 -> word_count=1, instruction at pc=0 is 16'h0123; pc=16'h0040 gives 16'h6000.
REQ-038 In RUN, load_start -> cpu_rst=1 next edge, word_count=0, all pc read 16'h6000 until the next load_end.
